// File: rtl/sync_split3.sv
// One-slot token splitter: routes each input token to one of three channels, or to all three.
// Dispatch happens the cycle after accept, in order; a token whose target channel is busy waits in the slot.
module sync_split3 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_drive,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [1:0]            i_dest,
   output logic                  o_free,
   output logic [2:0]            o_driveNext_3,
   output logic [DATA_WIDTH-1:0] o_data0,
   output logic [DATA_WIDTH-1:0] o_data1,
   output logic [DATA_WIDTH-1:0] o_data2,
   input  logic [2:0]            i_freeNext_3,
   output logic [15:0]           o_tok_cnt,
   output logic                  o_err
);

   logic                  in_full;
   logic [DATA_WIDTH-1:0] in_data;
   logic [1:0]            in_dest;
   logic [2:0]            ch_busy;

   logic [2:0] targets;
   logic       dispatch;
   logic       accept;
   logic       drop;
   logic       bad_free;

   always_comb begin
      targets  = (in_dest == 2'd3) ? 3'b111 : 3'(3'b001 << in_dest);
      // Broadcast is all-or-nothing: any busy target holds the whole token.
      dispatch = in_full && ((targets & ch_busy) == 3'b000);
      accept   = i_drive && (!in_full || dispatch);
      drop     = i_drive && !accept;
      bad_free = |(i_freeNext_3 & ~ch_busy);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_full       <= 1'b0;
         in_data       <= '0;
         in_dest       <= 2'd0;
         ch_busy       <= 3'b000;
         o_free        <= 1'b0;
         o_driveNext_3 <= 3'b000;
         o_data0       <= '0;
         o_data1       <= '0;
         o_data2       <= '0;
         o_tok_cnt     <= 16'd0;
         o_err         <= 1'b0;
      end else begin
         o_free        <= dispatch;
         o_driveNext_3 <= dispatch ? targets : 3'b000;
         if (dispatch && targets[0]) o_data0 <= in_data;
         if (dispatch && targets[1]) o_data1 <= in_data;
         if (dispatch && targets[2]) o_data2 <= in_data;
         ch_busy   <= (ch_busy & ~i_freeNext_3) | (dispatch ? targets : 3'b000);
         in_full   <= accept || (in_full && !dispatch);
         if (accept) begin
            in_data <= i_data;
            in_dest <= i_dest;
         end
         o_tok_cnt <= o_tok_cnt + {15'd0, dispatch};
         o_err     <= o_err || drop || bad_free;
      end
   end

endmodule

// File: tb/tb_sync_split3.sv
// Directed-vector bench for sync_split3 with hand-computed expectations.
module tb_sync_split3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_drive = 1'b0;
   logic [31:0] i_data = '0;
   logic [1:0]  i_dest = '0;
   logic [2:0]  i_freeNext_3 = '0;
   logic        o_free;
   logic [2:0]  o_driveNext_3;
   logic [31:0] o_data0, o_data1, o_data2;
   logic [15:0] o_tok_cnt;
   logic        o_err;

   int checks = 0;
   int errors = 0;

   sync_split3 #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .i_dest(i_dest),
      .o_free(o_free), .o_driveNext_3(o_driveNext_3),
      .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2),
      .i_freeNext_3(i_freeNext_3), .o_tok_cnt(o_tok_cnt), .o_err(o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; i_drive = 1'b0; i_freeNext_3 = 3'b000;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [1:0] dest, input logic [31:0] data);
      i_drive = 1'b1; i_dest = dest; i_data = data;
      tick();
      i_drive = 1'b0;
   endtask

   task automatic free_ch(input logic [2:0] mask);
      i_freeNext_3 = mask;
      tick();
      i_freeNext_3 = 3'b000;
   endtask

   int npulse;

   initial begin
      // Reset state
      do_reset();
      check("rst_drive", {29'd0, o_driveNext_3}, 32'd0);
      check("rst_free", {31'd0, o_free}, 32'd0);
      check("rst_data", o_data0 | o_data1 | o_data2, 32'd0);
      check("rst_cnt", {16'd0, o_tok_cnt}, 32'd0);
      check("rst_err", {31'd0, o_err}, 32'd0);

      // Unicast to channel 1: pulse at N+2
      send(2'd1, 32'hA5A5_0001);
      check("uni_n1_drive", {29'd0, o_driveNext_3}, 32'd0);
      tick();
      check("uni_drive", {29'd0, o_driveNext_3}, 32'b010);
      check("uni_free", {31'd0, o_free}, 32'd1);
      check("uni_data1", o_data1, 32'hA5A5_0001);
      check("uni_data0_hold", o_data0, 32'd0);
      check("uni_cnt", {16'd0, o_tok_cnt}, 32'd1);
      tick();
      check("uni_pulse_1cyc", {29'd0, o_driveNext_3}, 32'd0);
      free_ch(3'b010);
      check("uni_err", {31'd0, o_err}, 32'd0);

      // Blocking: second token to channel 0 waits for free; a third is dropped
      do_reset();
      send(2'd0, 32'h0000_00A0);
      tick();
      check("blk_first", {29'd0, o_driveNext_3}, 32'b001);
      send(2'd0, 32'h0000_00B0);
      tick(); tick();
      check("blk_held_drive", {29'd0, o_driveNext_3}, 32'd0);
      check("blk_held_free", {31'd0, o_free}, 32'd0);
      send(2'd2, 32'h0000_00C0);
      check("drop_err", {31'd0, o_err}, 32'd1);
      tick();
      check("drop_no_pulse", {29'd0, o_driveNext_3}, 32'd0);
      free_ch(3'b001);
      check("blk_m1", {29'd0, o_driveNext_3}, 32'd0);
      tick();
      check("blk_m2_drive", {29'd0, o_driveNext_3}, 32'b001);
      check("blk_m2_free", {31'd0, o_free}, 32'd1);
      check("blk_data0", o_data0, 32'h0000_00B0);
      check("blk_data2_untouched", o_data2, 32'd0);
      check("blk_cnt", {16'd0, o_tok_cnt}, 32'd2);
      tick();
      check("blk_no_third", {29'd0, o_driveNext_3}, 32'd0);
      check("drop_err_sticky", {31'd0, o_err}, 32'd1);

      // Spurious free on idle channel 2
      do_reset();
      check("sfree_err0", {31'd0, o_err}, 32'd0);
      free_ch(3'b100);
      check("sfree_err1", {31'd0, o_err}, 32'd1);
      send(2'd2, 32'h0000_0222);
      tick();
      check("sfree_then_ok", {29'd0, o_driveNext_3}, 32'b100);
      tick(); tick();
      check("sfree_err_sticky", {31'd0, o_err}, 32'd1);

      // Broadcast waits on busy channel 2, then goes to all at once
      do_reset();
      send(2'd2, 32'h0000_2222);
      tick();
      check("bc_pre", {29'd0, o_driveNext_3}, 32'b100);
      send(2'd3, 32'hBCBC_0003);
      tick(); tick();
      check("bc_held", {29'd0, o_driveNext_3}, 32'd0);
      free_ch(3'b100);
      check("bc_m1", {29'd0, o_driveNext_3}, 32'd0);
      tick();
      check("bc_drive", {29'd0, o_driveNext_3}, 32'b111);
      check("bc_free", {31'd0, o_free}, 32'd1);
      check("bc_data0", o_data0, 32'hBCBC_0003);
      check("bc_data1", o_data1, 32'hBCBC_0003);
      check("bc_data2", o_data2, 32'hBCBC_0003);
      check("bc_cnt", {16'd0, o_tok_cnt}, 32'd2);
      check("bc_err", {31'd0, o_err}, 32'd0);

      // Reset the cycle after dispatch, with a competing i_drive
      do_reset();
      send(2'd0, 32'h0000_0D0D);
      tick();
      check("mid_pulse", {29'd0, o_driveNext_3}, 32'b001);
      rst = 1'b1; i_drive = 1'b1; i_dest = 2'd1; i_data = 32'hDEAD_BEEF;
      tick();
      rst = 1'b0; i_drive = 1'b0;
      check("mid_drive", {29'd0, o_driveNext_3}, 32'd0);
      check("mid_free", {31'd0, o_free}, 32'd0);
      check("mid_data", o_data0 | o_data1 | o_data2, 32'd0);
      check("mid_cnt", {16'd0, o_tok_cnt}, 32'd0);
      tick(); tick();
      check("mid_no_ghost", {29'd0, o_driveNext_3}, 32'd0);
      send(2'd0, 32'h0000_0E0E);
      tick();
      check("mid_after", {29'd0, o_driveNext_3}, 32'b001);
      check("mid_after_data", o_data0, 32'h0000_0E0E);

      // Wrap: 65536 back-to-back unicasts rotating channels, frees echoed immediately
      do_reset();
      npulse = 0;
      for (int i = 0; i < 65536; i++) begin
         i_drive = 1'b1; i_dest = 2'(i % 3); i_data = i;
         i_freeNext_3 = o_driveNext_3;
         if (o_free) npulse++;
         tick();
      end
      i_drive = 1'b0;
      for (int j = 0; j < 6; j++) begin
         i_freeNext_3 = o_driveNext_3;
         if (o_free) npulse++;
         tick();
      end
      i_freeNext_3 = 3'b000;
      check("wrap_pulses", npulse, 32'd65536);
      check("wrap_cnt", {16'd0, o_tok_cnt}, 32'd0);
      check("wrap_no_drop", {31'd0, o_err}, 32'd0);
      check("wrap_last_data0", o_data0, 32'd65535);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
